// File: rtl/mainmem_pkg.sv
// Shared types and constants for the main-memory arbiter and its requesters.
package mainmem_pkg;

  localparam int unsigned MM_ADDR_W = 32;
  localparam int unsigned MM_DATA_W = 32;
  localparam int unsigned MM_BE_W   = MM_DATA_W / 8;

  localparam int unsigned REQ_IMEM0 = 0;
  localparam int unsigned REQ_IMEM1 = 1;
  localparam int unsigned REQ_DMEM0 = 2;
  localparam int unsigned REQ_DMEM1 = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [MM_ADDR_W-1:0] addr;
    logic [MM_BE_W-1:0]   byte_en;
    logic [MM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mainmem_arbiter_if.sv
// Requester-side and ext_mem-side bus of the main-memory arbiter.
interface mainmem_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*BE_W-1:0]   req_byte_en;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        resp_valid;
  logic [NREQ-1:0]        resp_ready;
  logic [DATA_W-1:0]      resp_rdata;

  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [ADDR_W-1:0]      mem_req_addr;
  logic [BE_W-1:0]        mem_req_byte_en;
  logic [DATA_W-1:0]      mem_req_wdata;
  logic                   mem_resp_valid;
  logic                   mem_resp_ready;
  logic [DATA_W-1:0]      mem_resp_rdata;

  modport slave (
    input  req_valid, req_addr, req_byte_en, req_wdata, resp_ready,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output req_ready, resp_valid, resp_rdata,
           mem_req_valid, mem_req_addr, mem_req_byte_en, mem_req_wdata, mem_resp_ready
  );

  modport master (
    output req_valid, req_addr, req_byte_en, req_wdata, resp_ready,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  req_ready, resp_valid, resp_rdata,
           mem_req_valid, mem_req_addr, mem_req_byte_en, mem_req_wdata, mem_resp_ready
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first set request at or after ptr, modulo N.
module rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  int unsigned      k;
  logic [IDX_W-1:0] kk;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    k     = 0;
    kk    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k  = (ptr + i) % N;
      kk = IDX_W'(k);
      if (!any && req[kk]) begin
        any       = 1'b1;
        grant[kk] = 1'b1;
        idx       = kk;
      end
    end
  end

endmodule

// File: rtl/mainmem_arbiter.sv
// Round-robin arbiter sharing the single ext_mem port among the cache requesters,
// one transaction outstanding at a time.
module mainmem_arbiter
  import mainmem_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = MM_ADDR_W,
  parameter int unsigned DATA_W = MM_DATA_W
) (
  input  logic                CLK,
  input  logic                RST_N,
  mainmem_arbiter_if.slave    bus,
  output logic [31:0]         busy_cycles
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BE_W  = DATA_W / 8;

  arb_state_t        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  cur_id;
  mem_req_t          req_q;
  logic [DATA_W-1:0] rdata_q;

  logic [NREQ-1:0]   pick_grant;
  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic              accept;

  rr_picker #(
    .N     (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  // req_ready is the only combinational output; gating with RST_N keeps it low during reset.
  assign accept        = (state == IDLE) && pick_any && RST_N;
  assign bus.req_ready = accept ? pick_grant : '0;

  assign bus.mem_req_valid   = (state == ISSUE);
  assign bus.mem_req_addr    = req_q.addr;
  assign bus.mem_req_byte_en = req_q.byte_en;
  assign bus.mem_req_wdata   = req_q.wdata;
  assign bus.mem_resp_ready  = (state == WAIT);
  assign bus.resp_rdata      = rdata_q;

  always_comb begin
    bus.resp_valid = '0;
    if (state == RESP) bus.resp_valid[cur_id] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cur_id      <= '0;
      req_q       <= '0;
      rdata_q     <= '0;
      busy_cycles <= '0;
    end else begin
      if (state != IDLE) busy_cycles <= busy_cycles + 32'd1;
      case (state)
        IDLE: begin
          if (pick_any) begin
            req_q.addr    <= bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
            req_q.byte_en <= bus.req_byte_en[pick_idx*BE_W +: BE_W];
            req_q.wdata   <= bus.req_wdata[pick_idx*DATA_W +: DATA_W];
            cur_id        <= pick_idx;
            state         <= ISSUE;
          end
        end
        ISSUE: if (bus.mem_req_ready) state <= WAIT;
        WAIT: begin
          if (bus.mem_resp_valid) begin
            rdata_q <= bus.mem_resp_rdata;
            state   <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready[cur_id]) begin
            rr_ptr <= (cur_id == IDX_W'(NREQ - 1)) ? '0 : cur_id + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SIMULATION
  always @(posedge CLK) begin
    if (RST_N && bus.mem_resp_valid && state != WAIT)
      $display("mainmem_arbiter: protocol error, mem_resp_valid outside WAIT at %0t", $time);
  end
`endif

endmodule
